// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Brief    : Shared types and constants for the calculator datapath.
// Revision : 1.0
// ============================================================================
package calc_pkg;

  localparam int CALC_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage
`default_nettype wire

// File: rtl/full_subtractor_cell.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor_cell
// Brief    : One-bit combinational full subtractor (x - y - bin).
// Revision : 1.0
// ============================================================================
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial a - b, LSB first, one bit per clock with a borrow flop.
//            Optional signed overflow flag: define SERIAL_SUB_OVF_EN.
// Revision : 1.0
// ============================================================================
module serial_subtractor
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

  sub_state_t       r_state;
  sub_state_t       w_state_nxt;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_nxt;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_borrow;
  logic             r_bout;
  logic             w_d;
  logic             w_bout;

  full_subtractor_cell u_cell (
    .x    (r_sa[0]),
    .y    (r_sb[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  // New difference bit enters at the MSB; after WIDTH shifts bit 0 is aligned.
  assign w_res_nxt = WIDTH'({w_d, r_res} >> 1);
  assign w_last    = (r_state == RUN) && (r_cnt == c_last_cnt);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_load      = 1'b1;
        end
      end
      RUN: begin
        if (r_cnt == c_last_cnt) w_state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_sa     <= a;
        r_sb     <= b;
        r_res    <= '0;
        r_cnt    <= '0;
        r_borrow <= 1'b0;
      end else if (r_state == RUN) begin
        r_sa     <= r_sa >> 1;
        r_sb     <= r_sb >> 1;
        r_res    <= w_res_nxt;
        r_cnt    <= r_cnt + CNT_W'(1);
        r_borrow <= w_bout;
      end
      if (w_last) begin
        r_diff <= w_res_nxt;
        r_bout <= w_bout;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= b[WIDTH-1];
      end
      if (w_last) r_ovf <= (r_a_msb ^ r_b_msb) & (w_res_nxt[WIDTH-1] ^ r_a_msb);
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign busy       = (r_state == RUN);
  assign done       = (r_state == DONE);
  assign diff       = r_diff;
  assign borrow_out = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Directed self-checking bench for serial_subtractor (WIDTH 8 and 1).
// Revision : 1.0
// ============================================================================
module tb_serial_subtractor;

`ifdef SERIAL_SUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, borrow_out, ovf;
  logic [7:0] diff;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       busy1, done1, borrow1, ovf1;
  logic [0:0] diff1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .ovf(ovf)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(borrow1), .ovf(ovf1)
  );

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] exp_d,
                      input logic exp_b, input logic exp_ovf_raw, input string name);
    int cyc;
    @(negedge clk); a = ta; b = tb; start = 1'b1;
    @(negedge clk); start = 1'b0; a = ~ta; b = ~tb;
    cyc = 1;
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy: got %b want 1", name, busy); end
    while (done !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    n_vec++;
    if (cyc !== 9) begin n_err++; $display("FAIL %s latency: got %0d want 9", name, cyc); end
    n_vec++;
    if (diff !== exp_d) begin n_err++; $display("FAIL %s diff: got %h want %h", name, diff, exp_d); end
    n_vec++;
    if (borrow_out !== exp_b) begin n_err++; $display("FAIL %s borrow: got %b want %b", name, borrow_out, exp_b); end
    n_vec++;
    if (ovf !== (exp_ovf_raw & OVF_ON)) begin
      n_err++; $display("FAIL %s ovf: got %b want %b", name, ovf, exp_ovf_raw & OVF_ON);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL %s done_pulse: got %b want 0", name, done); end
  endtask

  task automatic run1(input logic ta, input logic tb, input logic exp_d, input logic exp_b,
                      input logic exp_ovf_raw, input string name);
    int cyc;
    @(negedge clk); a1 = ta; b1 = tb; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; a1 = ~ta; b1 = ~tb;
    cyc = 1;
    while (done1 !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    n_vec++;
    if (cyc !== 2) begin n_err++; $display("FAIL %s latency: got %0d want 2", name, cyc); end
    n_vec++;
    if (diff1 !== exp_d) begin n_err++; $display("FAIL %s diff: got %b want %b", name, diff1, exp_d); end
    n_vec++;
    if (borrow1 !== exp_b) begin n_err++; $display("FAIL %s borrow: got %b want %b", name, borrow1, exp_b); end
    n_vec++;
    if (ovf1 !== (exp_ovf_raw & OVF_ON)) begin
      n_err++; $display("FAIL %s ovf: got %b want %b", name, ovf1, exp_ovf_raw & OVF_ON);
    end
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({busy, done, diff, borrow_out, ovf} !== 12'h000) begin
      n_err++; $display("FAIL reset_state: got %b%b %h %b%b want all 0", busy, done, diff, borrow_out, ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy, done, busy1, done1} !== 4'b0000) begin
      n_err++; $display("FAIL reset_idle: got %b%b%b%b want 0000", busy, done, busy1, done1);
    end
  endtask

  task automatic test_basic();
    logic [7:0] va [6] = '{8'h5A, 8'h10, 8'h80, 8'h7F, 8'hA5, 8'h00};
    logic [7:0] vb [6] = '{8'h3C, 8'h20, 8'h01, 8'hFF, 8'hA5, 8'h01};
    logic [7:0] vd [6] = '{8'h1E, 8'hF0, 8'h7F, 8'h80, 8'h00, 8'hFF};
    logic       vbo[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       vov[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      run8(va[i], vb[i], vd[i], vbo[i], vov[i], $sformatf("basic%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] oa [3] = '{8'h33, 8'h05, 8'hC8};
    logic [7:0] ob [3] = '{8'h11, 8'h09, 8'h64};
    logic [7:0] od [3] = '{8'h22, 8'hFC, 8'h64};
    logic       obo[3] = '{1'b0, 1'b1, 1'b0};
    int cyc;
    @(negedge clk); a = oa[0]; b = ob[0]; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cyc = 1;
      if (k < 2) begin
        a = oa[k+1]; b = ob[k+1];
      end else begin
        start = 1'b0; a = 8'hFF; b = 8'h00;
      end
      while (done !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
      n_vec++;
      if (cyc !== 9) begin n_err++; $display("FAIL b2b%0d interval: got %0d want 9", k, cyc); end
      n_vec++;
      if (diff !== od[k]) begin n_err++; $display("FAIL b2b%0d diff: got %h want %h", k, diff, od[k]); end
      n_vec++;
      if (borrow_out !== obo[k]) begin
        n_err++; $display("FAIL b2b%0d borrow: got %b want %b", k, borrow_out, obo[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    @(negedge clk); a = 8'h5A; b = 8'h3C; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, diff, borrow_out, ovf} !== 12'h000) begin
      n_err++; $display("FAIL midrun_reset: got %b%b %h %b%b want all 0", busy, done, diff, borrow_out, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin @(negedge clk); if (done === 1'b1) saw_done = 1'b1; end
    n_vec++;
    if (saw_done) begin n_err++; $display("FAIL midrun_no_done: got done=1 want none"); end
    run8(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_width1();
    run1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "w1_0m1");
    run1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "w1_1m0");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
